color_select_ctrl: RTL and testbench
====================================

Name: color_select_ctrl

Overview:
- Upstream control stage for the colour-detect/highlight stage in the D8M camera-to-VGA path.
- Debounces two DE1-SoC pushbuttons (next/prev) and cycles the 2-bit highlight select (00 red, 01 green, 10 blue).
- Commits a new selection only at a frame boundary (VSYNC falling edge), so the highlight colour never changes mid-frame.
- Guarantees the select output never takes the value 11.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive clocks a synchronised key level must differ from the stable level before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
CNT_W, 20, width of each debounce counter.

Ports:
clk  in  1  pixel/system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
key_next_n  in  1  raw pushbutton, active-low, asynchronous to clk; a press advances the selection.
key_prev_n  in  1  raw pushbutton, active-low, asynchronous to clk; a press steps the selection back.
vga_vs_n  in  1  active-low vertical sync, synchronous to clk.
ctrl  out  2  committed highlight select to the colour-detect stage: 00 red, 01 green, 10 blue.
pending  out  1  high when the queued selection differs from ctrl.
key_evt  out  1  one-cycle pulse on each accepted press of either key.

Behaviour:
- Reset, async on rst_n low:
  - ctrl=00, next_sel=00, pending=0, key_evt=0.
  - Synchroniser flops and stable key levels =1 (released); debounce counters =0; vs_q=1.
- Synchronisers: two flops per key.
- Debounce, per key, on every clk:
  - If sync==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sync, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to the stable level clears the count.
- Press event: stable transitions 1->0. Release (0->1) produces no event.
- key_evt: registered OR of both press events; high exactly one cycle after stable falls.
- next_sel update, in the cycle a press event is registered:
  - next only: 00->01->10->00.
  - prev only: 00->10->01->00.
  - Both in the same cycle: no change, and key_evt still pulses.
- Frame commit:
  - vs_q<=vga_vs_n each cycle; fall = vs_q & ~vga_vs_n.
  - On an edge with fall=1: ctrl<=next_sel, using the next_sel value held before that edge.
  - ctrl is visible the cycle after VSYNC is first sampled low.
- Simultaneous press and fall:
  - The commit uses the old next_sel.
  - The new next_sel remains queued and pending=1 until the next frame.
- Multiple presses within one frame: only the last next_sel is committed; intermediate values are never driven on ctrl.
- pending: registered, equals (next_sel != ctrl) evaluated on updated values; 0 immediately after a commit unless a press coincided with it.
- VSYNC held low or high indefinitely: no further commits, because the commit is edge-triggered only.
- ctrl, next_sel: 11 is unreachable. If either is ever 11 (SEU/X-prop), the next update forces it to 00.
- Reset mid-debounce or mid-frame: all state returns to reset values. No commit or event is generated on reset release, even if keys are held. A key held through reset is accepted as a press only after DEBOUNCE_CYCLES.
- Counter width: instantiation-time check that DEBOUNCE_CYCLES < 2^CNT_W.

Test Plan:
- Reset, keys released, vga_vs_n toggling -> ctrl=00, pending=0, key_evt never asserted.
- DEBOUNCE_CYCLES=4: key_next_n low for 3 cycles then high (bounce), repeated -> no key_evt, next_sel stays 00. Hold it low 10 cycles -> one key_evt pulse; pending=1; ctrl stays 00 until the next vga_vs_n fall, then ctrl=01 and pending=0.
- Three next presses within one frame -> next_sel 01,10,00; pending ends 0; at the VSYNC fall ctrl stays 00 and never shows 01 or 10.
- prev press from ctrl=00 followed by a VSYNC fall -> ctrl=10. Second prev press and fall -> ctrl=01.
- Both keys' stable levels fall in the same cycle -> one key_evt pulse, next_sel unchanged, pending=0.
- Press registered on the same edge as the VSYNC fall, with next_sel=01 and ctrl=00 beforehand -> ctrl=01 and next_sel=10 (pending=1). The following fall gives ctrl=10. Assert rst_n low mid-frame -> ctrl=00 immediately (async), with no commit on release.

Source files
------------

// File: rtl/color_select_ctrl.sv
// rtl/color_select_ctrl.sv - debounced next/prev keys cycling a 2-bit highlight select, committed on VSYNC fall
module color_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_next_n,
    input  logic       i_key_prev_n,
    input  logic       i_vga_vs_n,
    output logic [1:0] o_ctrl,
    output logic       o_pending,
    output logic       o_key_evt
);

    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b01;
    localparam logic [1:0] SEL_BLUE  = 2'b10;
    localparam logic [1:0] SEL_BAD   = 2'b11;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
        $error("color_select_ctrl: DEBOUNCE_CYCLES must be in 2 .. 2**CNT_W-1");
    end

    // Bit 0 carries the next key, bit 1 the prev key.
    logic [1:0] w_key_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_stable;
    logic [1:0] r_stable_d;
    logic [1:0] w_press;

    assign w_key_raw = {i_key_prev_n, i_key_next_n};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_stable_d <= 2'b11;
        end else begin
            r_sync1    <= w_key_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;

        // Any return to the stable level restarts the qualification window.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt       <= '0;
                r_stable[k] <= 1'b1;
            end else if (r_sync2[k] == r_stable[k]) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_MAX) begin
                r_stable[k] <= r_sync2[k];
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_press = r_stable_d & ~r_stable;

    logic       r_vs_q;
    logic [1:0] r_next_sel;
    logic [1:0] r_ctrl;
    logic       r_pending;
    logic       r_key_evt;
    logic       w_fall;
    logic [1:0] w_sel_clean;
    logic [1:0] w_ctrl_clean;
    logic [1:0] w_next_sel_d;
    logic [1:0] w_ctrl_d;

    assign w_fall = r_vs_q & ~i_vga_vs_n;

    always_comb begin
        w_sel_clean  = (r_next_sel == SEL_BAD) ? SEL_RED : r_next_sel;
        w_ctrl_clean = (r_ctrl == SEL_BAD) ? SEL_RED : r_ctrl;
        w_next_sel_d = w_sel_clean;
        case (w_press)
            2'b01: begin
                case (w_sel_clean)
                    SEL_RED:   w_next_sel_d = SEL_GREEN;
                    SEL_GREEN: w_next_sel_d = SEL_BLUE;
                    default:   w_next_sel_d = SEL_RED;
                endcase
            end
            2'b10: begin
                case (w_sel_clean)
                    SEL_RED:  w_next_sel_d = SEL_BLUE;
                    SEL_BLUE: w_next_sel_d = SEL_GREEN;
                    default:  w_next_sel_d = SEL_RED;
                endcase
            end
            default: w_next_sel_d = w_sel_clean;
        endcase
        // The commit takes the selection held before this edge, so a coinciding press stays queued.
        w_ctrl_d = w_fall ? w_sel_clean : w_ctrl_clean;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_q     <= 1'b1;
            r_next_sel <= SEL_RED;
            r_ctrl     <= SEL_RED;
            r_pending  <= 1'b0;
            r_key_evt  <= 1'b0;
        end else begin
            r_vs_q     <= i_vga_vs_n;
            r_next_sel <= w_next_sel_d;
            r_ctrl     <= w_ctrl_d;
            r_pending  <= (w_next_sel_d != w_ctrl_d);
            r_key_evt  <= |w_press;
        end
    end

    assign o_ctrl    = r_ctrl;
    assign o_pending = r_pending;
    assign o_key_evt = r_key_evt;

endmodule

// File: tb/tb_color_select_ctrl.sv
// tb/tb_color_select_ctrl.sv - directed self-checking bench for color_select_ctrl
module tb_color_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_next_n;
    logic       key_prev_n;
    logic       vga_vs_n;
    logic [1:0] ctrl;
    logic       pending;
    logic       key_evt;

    int n_cmp = 0;
    int n_bad = 0;
    int evt_cnt = 0;
    int nz_cnt = 0;

    color_select_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_next_n(key_next_n),
        .i_key_prev_n(key_prev_n),
        .i_vga_vs_n  (vga_vs_n),
        .o_ctrl      (ctrl),
        .o_pending   (pending),
        .o_key_evt   (key_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_evt === 1'b1) evt_cnt++;
        if (ctrl !== 2'b00) nz_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        vga_vs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press(input logic nxt, input logic prv);
        if (nxt) key_next_n = 1'b0;
        if (prv) key_prev_n = 1'b0;
        tick(10);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        tick(8);
    endtask

    task automatic vs_frame();
        vga_vs_n = 1'b0;
        tick(3);
        vga_vs_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        vga_vs_n = 1'b1;
        #1;
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL reset_ctrl got %b want 00", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", pending); end
        n_cmp++; if (key_evt !== 1'b0) begin n_bad++; $display("FAIL reset_evt got %b want 0", key_evt); end
        tick(2);
        rst_n = 1'b1;
        base = evt_cnt;
        repeat (3) vs_frame();
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL idle_ctrl got %b want 00", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL idle_pending got %b want 0", pending); end
        n_cmp++; if (evt_cnt - base != 0) begin n_bad++; $display("FAIL idle_evt got %0d want 0", evt_cnt - base); end
    endtask

    task automatic test_debounce();
        int base;
        base = evt_cnt;
        repeat (3) begin
            key_next_n = 1'b0;
            tick(3);
            key_next_n = 1'b1;
            tick(4);
        end
        n_cmp++; if (evt_cnt - base != 0) begin n_bad++; $display("FAIL bounce_evt got %0d want 0", evt_cnt - base); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL bounce_pending got %b want 0", pending); end
        press(1'b1, 1'b0);
        n_cmp++; if (evt_cnt - base != 1) begin n_bad++; $display("FAIL hold_evt got %0d want 1", evt_cnt - base); end
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL hold_pending got %b want 1", pending); end
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL hold_ctrl got %b want 00", ctrl); end
        vs_frame();
        n_cmp++; if (ctrl !== 2'b01) begin n_bad++; $display("FAIL commit_ctrl got %b want 01", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL commit_pending got %b want 0", pending); end
    endtask

    task automatic test_multi_press();
        int base;
        int nzb;
        do_reset();
        base = evt_cnt;
        nzb = nz_cnt;
        press(1'b1, 1'b0);
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL multi1_pending got %b want 1", pending); end
        press(1'b1, 1'b0);
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL multi2_pending got %b want 1", pending); end
        press(1'b1, 1'b0);
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL multi3_pending got %b want 0", pending); end
        n_cmp++; if (evt_cnt - base != 3) begin n_bad++; $display("FAIL multi_evt got %0d want 3", evt_cnt - base); end
        vs_frame();
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL multi_ctrl got %b want 00", ctrl); end
        n_cmp++; if (nz_cnt - nzb != 0) begin n_bad++; $display("FAIL multi_glitch got %0d nonzero ctrl samples want 0", nz_cnt - nzb); end
    endtask

    task automatic test_prev();
        do_reset();
        press(1'b0, 1'b1);
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL prev1_pending got %b want 1", pending); end
        vs_frame();
        n_cmp++; if (ctrl !== 2'b10) begin n_bad++; $display("FAIL prev1_ctrl got %b want 10", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL prev1_commit_pending got %b want 0", pending); end
        press(1'b0, 1'b1);
        vs_frame();
        n_cmp++; if (ctrl !== 2'b01) begin n_bad++; $display("FAIL prev2_ctrl got %b want 01", ctrl); end
    endtask

    task automatic test_both_keys();
        int base;
        base = evt_cnt;
        press(1'b1, 1'b1);
        n_cmp++; if (evt_cnt - base != 1) begin n_bad++; $display("FAIL both_evt got %0d want 1", evt_cnt - base); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL both_pending got %b want 0", pending); end
        vs_frame();
        n_cmp++; if (ctrl !== 2'b01) begin n_bad++; $display("FAIL both_ctrl got %b want 01", ctrl); end
    endtask

    task automatic test_coincide();
        do_reset();
        press(1'b1, 1'b0);
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL coin_pre_ctrl got %b want 00", ctrl); end
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL coin_pre_pending got %b want 1", pending); end
        key_next_n = 1'b0;
        tick(6);
        n_cmp++; if (key_evt !== 1'b0) begin n_bad++; $display("FAIL coin_early_evt got %b want 0", key_evt); end
        vga_vs_n = 1'b0;
        tick(1);
        n_cmp++; if (ctrl !== 2'b01) begin n_bad++; $display("FAIL coin_ctrl got %b want 01", ctrl); end
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL coin_pending got %b want 1", pending); end
        n_cmp++; if (key_evt !== 1'b1) begin n_bad++; $display("FAIL coin_evt got %b want 1", key_evt); end
        key_next_n = 1'b1;
        tick(3);
        vga_vs_n = 1'b1;
        tick(8);
        n_cmp++; if (ctrl !== 2'b01) begin n_bad++; $display("FAIL coin_hold_ctrl got %b want 01", ctrl); end
        vs_frame();
        n_cmp++; if (ctrl !== 2'b10) begin n_bad++; $display("FAIL coin_next_ctrl got %b want 10", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL coin_next_pending got %b want 0", pending); end
    endtask

    task automatic test_reset_mid();
        int base;
        key_next_n = 1'b0;
        vga_vs_n = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 00", ctrl); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rstmid_pending got %b want 0", pending); end
        tick(2);
        rst_n = 1'b1;
        base = evt_cnt;
        tick(5);
        n_cmp++; if (ctrl !== 2'b00) begin n_bad++; $display("FAIL rstrel_ctrl got %b want 00", ctrl); end
        n_cmp++; if (evt_cnt - base != 0) begin n_bad++; $display("FAIL rstrel_evt got %0d want 0", evt_cnt - base); end
        tick(5);
        n_cmp++; if (evt_cnt - base != 1) begin n_bad++; $display("FAIL held_key_evt got %0d want 1", evt_cnt - base); end
        n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL held_key_pending got %b want 1", pending); end
        key_next_n = 1'b1;
        vga_vs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_multi_press();
        test_prev();
        test_both_keys();
        test_coincide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
